// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotated-priority search: first set request starting one past the last grantee.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] onehot,
    output logic [1:0]      idx,
    output logic            any
);

    sel_t cand;
    logic found;

    always_comb begin
        onehot = '0;
        idx    = last;
        cand   = last;
        found  = 1'b0;
        // Offsets 1..NREQ wrap, so the last grantee is examined last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + sel_t'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/four_way_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a bounded
// hold time and a one-cycle idle bubble after every release.
module four_way_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            busy,
    output logic            timeout
);

    arb_state_t        state_p0, state_p1;
    logic [NREQ-1:0]   gnt_p0, gnt_p1;
    sel_t              sel_p0, sel_p1;
    sel_t              last_p0, last_p1;
    logic [HOLD_W-1:0] cnt_p0, cnt_p1;
    logic              timeout_p0, timeout_p1;

    logic [NREQ-1:0]   pick_onehot;
    sel_t              pick_idx;
    logic              pick_any;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
        return (c == HOLD_W'(MAX_HOLD)) ? c : c + HOLD_W'(1);
    endfunction

    rr_pick u_pick (
        .req    (req),
        .last   (last_p1),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // ---- stage p0: next-state decision ----
    always_comb begin
        state_p0   = state_p1;
        gnt_p0     = gnt_p1;
        sel_p0     = sel_p1;
        last_p0    = last_p1;
        cnt_p0     = cnt_p1;
        timeout_p0 = 1'b0;
        unique case (state_p1)
            IDLE: begin
                gnt_p0 = '0;
                if (pick_any) begin
                    state_p0 = BUSY;
                    gnt_p0   = pick_onehot;
                    sel_p0   = pick_idx;
                    cnt_p0   = HOLD_W'(1);
                end
            end
            BUSY: begin
                if (!req[sel_p1]) begin
                    // Voluntary release wins even when the hold limit is reached.
                    state_p0 = IDLE;
                    gnt_p0   = '0;
                    last_p0  = sel_p1;
                    cnt_p0   = '0;
                end else if (cnt_p1 < HOLD_W'(MAX_HOLD)) begin
                    cnt_p0 = hold_inc(cnt_p1);
                end else begin
                    state_p0   = IDLE;
                    gnt_p0     = '0;
                    last_p0    = sel_p1;
                    cnt_p0     = '0;
                    timeout_p0 = 1'b1;
                end
            end
            default: begin
                state_p0 = IDLE;
                gnt_p0   = '0;
                cnt_p0   = '0;
            end
        endcase
    end

    // ---- stage p1: registered state and outputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1   <= IDLE;
            gnt_p1     <= '0;
            sel_p1     <= '0;
            last_p1    <= sel_t'(NREQ - 1);
            cnt_p1     <= '0;
            timeout_p1 <= 1'b0;
        end else begin
            state_p1   <= state_p0;
            gnt_p1     <= gnt_p0;
            sel_p1     <= sel_p0;
            last_p1    <= last_p0;
            cnt_p1     <= cnt_p0;
            timeout_p1 <= timeout_p0;
        end
    end

    always_comb begin
        gnt     = gnt_p1;
        sel     = sel_p1;
        busy    = |gnt_p1;
        timeout = timeout_p1;
    end

endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// Directed bench for four_way_rr_arbiter with MAX_HOLD=4.
module tb_four_way_rr_arbiter;

    localparam int MH = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    four_way_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before bench completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        step();
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else passed++;
        total++; if (sel !== 2'b00) $display("FAIL reset_sel: got %b want 00", sel); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
        reset_n = 1'b1;
        step();
        total++; if (gnt !== 4'b0001) $display("FAIL first_gnt: got %b want 0001", gnt); else passed++;
        total++; if (sel !== 2'b00) $display("FAIL first_sel: got %b want 00", sel); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL first_busy: got %b want 1", busy); else passed++;
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL first_release_gnt: got %b want 0000", gnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL first_release_busy: got %b want 0", busy); else passed++;
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            step();
            total++; if (gnt !== 4'b0100) $display("FAIL single_gnt c%0d: got %b want 0100", c, gnt); else passed++;
            total++; if (sel !== 2'b10) $display("FAIL single_sel c%0d: got %b want 10", c, sel); else passed++;
            total++; if (timeout !== 1'b0) $display("FAIL single_timeout c%0d: got %b want 0", c, timeout); else passed++;
        end
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL single_release_gnt: got %b want 0000", gnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_release_busy: got %b want 0", busy); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL single_release_timeout: got %b want 0", timeout); else passed++;
        step();
        total++; if (sel !== 2'b10) $display("FAIL single_sel_hold_idle: got %b want 10", sel); else passed++;
    endtask

    task automatic test_rotation();
        logic [3:0] e;
        logic [1:0] ei;
        req = 4'b0000;
        pulse_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            ei = 2'(n % 4);
            e  = 4'(1 << (n % 4));
            step();
            total++; if (gnt !== e) $display("FAIL rot_grant n%0d: got %b want %b", n, gnt, e); else passed++;
            total++; if (sel !== ei) $display("FAIL rot_sel n%0d: got %b want %b", n, sel, ei); else passed++;
            step();
            total++; if (gnt !== e) $display("FAIL rot_hold n%0d: got %b want %b", n, gnt, e); else passed++;
            req = 4'b1111 & ~e;
            step();
            total++; if (gnt !== 4'b0000) $display("FAIL rot_bubble n%0d: got %b want 0000", n, gnt); else passed++;
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        for (int c = 1; c <= MH; c++) begin
            step();
            total++; if (gnt !== 4'b0010) $display("FAIL to_hold c%0d: got %b want 0010", c, gnt); else passed++;
            total++; if (timeout !== 1'b0) $display("FAIL to_early_pulse c%0d: got %b want 0", c, timeout); else passed++;
        end
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL to_revoke_gnt: got %b want 0000", gnt); else passed++;
        total++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b want 1", timeout); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL to_revoke_busy: got %b want 0", busy); else passed++;
        step();
        total++; if (gnt !== 4'b0010) $display("FAIL to_regrant: got %b want 0010", gnt); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", timeout); else passed++;
        // Hold up to the limit, then drop request exactly at the revoke edge.
        for (int c = 2; c <= MH; c++) step();
        total++; if (gnt !== 4'b0010) $display("FAIL to_full_hold: got %b want 0010", gnt); else passed++;
        req = 4'b0000;
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL to_vol_at_limit_gnt: got %b want 0000", gnt); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL to_vol_at_limit_pulse: got %b want 0", timeout); else passed++;
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] e;
        req = 4'b0000;
        pulse_reset();
        req = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            e = (n % 2 == 0) ? 4'b0001 : 4'b1000;
            step();
            total++; if (gnt !== e) $display("FAIL fair_grant n%0d: got %b want %b", n, gnt, e); else passed++;
            for (int c = 2; c <= MH; c++) step();
            total++; if (gnt !== e) $display("FAIL fair_last_hold n%0d: got %b want %b", n, gnt, e); else passed++;
            step();
            total++; if (gnt !== 4'b0000) $display("FAIL fair_revoke n%0d: got %b want 0000", n, gnt); else passed++;
            total++; if (timeout !== 1'b1) $display("FAIL fair_pulse n%0d: got %b want 1", n, timeout); else passed++;
        end
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        step();
        total++; if (gnt !== 4'b1000) $display("FAIL ar_grant: got %b want 1000", gnt); else passed++;
        step();
        total++; if (gnt !== 4'b1000) $display("FAIL ar_count2: got %b want 1000", gnt); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (gnt !== 4'b0000) $display("FAIL ar_gnt_now: got %b want 0000", gnt); else passed++;
        total++; if (sel !== 2'b00) $display("FAIL ar_sel_now: got %b want 00", sel); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ar_busy_now: got %b want 0", busy); else passed++;
        total++; if (timeout !== 1'b0) $display("FAIL ar_timeout_now: got %b want 0", timeout); else passed++;
        #1;
        reset_n = 1'b1;
        for (int c = 1; c <= MH; c++) begin
            step();
            total++; if (gnt !== 4'b1000) $display("FAIL ar_fresh c%0d: got %b want 1000", c, gnt); else passed++;
            total++; if (timeout !== 1'b0) $display("FAIL ar_fresh_pulse c%0d: got %b want 0", c, timeout); else passed++;
        end
        step();
        total++; if (gnt !== 4'b0000) $display("FAIL ar_revoke: got %b want 0000", gnt); else passed++;
        total++; if (timeout !== 1'b1) $display("FAIL ar_pulse: got %b want 1", timeout); else passed++;
        req = 4'b0000;
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_fairness();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
